// File: rtl/alu_issue_if.sv
// alu_issue_if: upstream offer, downstream issue and flush bundle for alu_issue.
// Rev 1.0
`default_nettype none

interface alu_issue_if;
  logic        flush;
  logic        inValid;
  logic        inReady;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] rs1Data;
  logic [31:0] rs2Data;
  logic        outValid;
  logic        outReady;
  logic [31:0] aluIn0;
  logic [31:0] aluIn1;
  logic [3:0]  aluOp;
  logic        isBranch;
  logic [31:0] branchTarget;
  logic        illegal;

  modport master (
    output flush, inValid, instr, pc, rs1Data, rs2Data, outReady,
    input  inReady, outValid, aluIn0, aluIn1, aluOp, isBranch, branchTarget, illegal
  );

  modport slave (
    input  flush, inValid, instr, pc, rs1Data, rs2Data, outReady,
    output inReady, outValid, aluIn0, aluIn1, aluOp, isBranch, branchTarget, illegal
  );
endinterface

`default_nettype wire

// File: rtl/alu_issue.sv
// alu_issue: RV32I decode into ALU operands/op, held in a one-entry pipeline register.
// Rev 1.0
`default_nettype none

module alu_issue (
  input  wire logic   clk,
  input  wire logic   rstN,
  alu_issue_if.slave  bus
);

  localparam logic [3:0] OP_EQ  = 4'b0000;
  localparam logic [3:0] OP_NE  = 4'b0001;
  localparam logic [3:0] OP_LT  = 4'b0010;
  localparam logic [3:0] OP_GE  = 4'b0011;
  localparam logic [3:0] OP_LTU = 4'b0100;
  localparam logic [3:0] OP_GEU = 4'b0101;
  localparam logic [3:0] OP_ADD = 4'b0110;
  localparam logic [3:0] OP_XOR = 4'b0111;
  localparam logic [3:0] OP_OR  = 4'b1000;
  localparam logic [3:0] OP_AND = 4'b1001;
  localparam logic [3:0] OP_SUB = 4'b1010;
  localparam logic [3:0] OP_SLL = 4'b1011;
  localparam logic [3:0] OP_SRL = 4'b1100;
  localparam logic [3:0] OP_SRA = 4'b1101;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;

  logic [3:0]  dec_op;
  logic [31:0] dec_in0;
  logic [31:0] dec_in1;
  logic        dec_branch;
  logic        dec_illegal;
  logic [3:0]  arith_op;
  logic        arith_ok;

  logic        in_ready;
  logic        transfer;

  logic        out_valid;
  logic [31:0] alu_in0;
  logic [31:0] alu_in1;
  logic [3:0]  alu_op;
  logic        is_branch;
  logic [31:0] branch_target;
  logic        illegal_q;

  assign opcode = bus.instr[6:0];
  assign funct3 = bus.instr[14:12];
  assign funct7 = bus.instr[31:25];
  assign imm_i  = {{20{bus.instr[31]}}, bus.instr[31:20]};
  assign imm_s  = {{20{bus.instr[31]}}, bus.instr[31:25], bus.instr[11:7]};
  assign imm_b  = {{19{bus.instr[31]}}, bus.instr[31], bus.instr[7],
                   bus.instr[30:25], bus.instr[11:8], 1'b0};
  assign imm_u  = {bus.instr[31:12], 12'b0};

  // Shared OP / OP-IMM funct3 mapping; funct7 legality differs between the two
  // (OP-IMM carries immediate bits there except for shifts).
  always_comb begin
    arith_op = OP_ADD;
    arith_ok = 1'b1;
    unique case (funct3)
      3'b000: arith_op = OP_ADD;
      3'b001: arith_op = OP_SLL;
      3'b010: arith_op = OP_LT;
      3'b011: arith_op = OP_LTU;
      3'b100: arith_op = OP_XOR;
      3'b101: arith_op = (funct7 == F7_ALT) ? OP_SRA : OP_SRL;
      3'b110: arith_op = OP_OR;
      3'b111: arith_op = OP_AND;
      default: arith_ok = 1'b0;
    endcase
  end

  always_comb begin
    dec_op      = OP_ADD;
    dec_in0     = 32'd0;
    dec_in1     = 32'd0;
    dec_branch  = 1'b0;
    dec_illegal = 1'b0;
    if (bus.instr[1:0] != 2'b11) begin
      dec_illegal = 1'b1;
    end else begin
      case (opcode)
        OPC_OP: begin
          dec_in0 = bus.rs1Data;
          dec_in1 = bus.rs2Data;
          dec_op  = arith_op;
          if (funct7 == F7_ALT) begin
            if (funct3 == 3'b000) dec_op = OP_SUB;
            else if (funct3 != 3'b101) dec_illegal = 1'b1;
          end else if (funct7 != F7_ZERO) begin
            dec_illegal = 1'b1;
          end
          if (!arith_ok) dec_illegal = 1'b1;
        end
        OPC_OPIMM: begin
          dec_in0 = bus.rs1Data;
          dec_in1 = imm_i;
          dec_op  = arith_op;
          if (funct3 == 3'b001 && funct7 != F7_ZERO) dec_illegal = 1'b1;
          if (funct3 == 3'b101 && funct7 != F7_ZERO && funct7 != F7_ALT) dec_illegal = 1'b1;
          if (!arith_ok) dec_illegal = 1'b1;
        end
        OPC_BRANCH: begin
          dec_in0    = bus.rs1Data;
          dec_in1    = bus.rs2Data;
          dec_branch = 1'b1;
          case (funct3)
            3'b000:  dec_op = OP_EQ;
            3'b001:  dec_op = OP_NE;
            3'b100:  dec_op = OP_LT;
            3'b101:  dec_op = OP_GE;
            3'b110:  dec_op = OP_LTU;
            3'b111:  dec_op = OP_GEU;
            default: dec_illegal = 1'b1;
          endcase
        end
        OPC_LUI: begin
          dec_in1 = imm_u;
        end
        OPC_AUIPC: begin
          dec_in0 = bus.pc;
          dec_in1 = imm_u;
        end
        OPC_LOAD: begin
          dec_in0 = bus.rs1Data;
          dec_in1 = imm_i;
        end
        OPC_STORE: begin
          dec_in0 = bus.rs1Data;
          dec_in1 = imm_s;
        end
        default: dec_illegal = 1'b1;
      endcase
    end
    // Undecodable words always present the same neutral operand set.
    if (dec_illegal) begin
      dec_op     = OP_ADD;
      dec_in0    = 32'd0;
      dec_in1    = 32'd0;
      dec_branch = 1'b0;
    end
  end

  assign in_ready = (!out_valid || bus.outReady) && !bus.flush;
  assign transfer = bus.inValid && in_ready;

  always_ff @(posedge clk) begin
    if (!rstN) begin
      out_valid     <= 1'b0;
      alu_in0       <= 32'd0;
      alu_in1       <= 32'd0;
      alu_op        <= OP_ADD;
      is_branch     <= 1'b0;
      branch_target <= 32'd0;
      illegal_q     <= 1'b0;
    end else if (transfer) begin
      out_valid     <= 1'b1;
      alu_in0       <= dec_in0;
      alu_in1       <= dec_in1;
      alu_op        <= dec_op;
      is_branch     <= dec_branch;
      branch_target <= bus.pc + imm_b;
      illegal_q     <= dec_illegal;
    end else if (bus.flush || bus.outReady) begin
      out_valid <= 1'b0;
    end
  end

  assign bus.inReady      = in_ready;
  assign bus.outValid     = out_valid;
  assign bus.aluIn0       = alu_in0;
  assign bus.aluIn1       = alu_in1;
  assign bus.aluOp        = alu_op;
  assign bus.isBranch     = is_branch;
  assign bus.branchTarget = branch_target;
  assign bus.illegal      = illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed self-checking bench for alu_issue.
// Rev 1.0
`default_nettype none

module tb_alu_issue;

  logic clk;
  logic rstN;
  int   n_checks;
  int   n_fail;

  alu_issue_if bus ();

  alu_issue dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [3:0]  op;
    logic [31:0] in0;
    logic [31:0] in1;
    logic        br;
    logic        ill;
    logic        chk_bt;
    logic [31:0] bt;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] i, input logic [31:0] p,
                       input logic [31:0] a, input logic [31:0] b);
    bus.inValid = 1'b1;
    bus.instr   = i;
    bus.pc      = p;
    bus.rs1Data = a;
    bus.rs2Data = b;
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    bus.flush = 1'b0;
    bus.outReady = 1'b0;
    offer(32'h40B50533, 32'h0, 32'd5, 32'd7);
    bus.inValid = 1'b0;
    step();
    step();
    n_checks++; if (bus.outValid !== 1'b0) begin n_fail++; $display("FAIL reset outValid got %b exp 0", bus.outValid); end
    n_checks++; if (bus.aluIn0 !== 32'd0) begin n_fail++; $display("FAIL reset aluIn0 got %h exp 0", bus.aluIn0); end
    n_checks++; if (bus.aluIn1 !== 32'd0) begin n_fail++; $display("FAIL reset aluIn1 got %h exp 0", bus.aluIn1); end
    n_checks++; if (bus.aluOp !== 4'b0110) begin n_fail++; $display("FAIL reset aluOp got %b exp 0110", bus.aluOp); end
    n_checks++; if (bus.isBranch !== 1'b0) begin n_fail++; $display("FAIL reset isBranch got %b exp 0", bus.isBranch); end
    n_checks++; if (bus.illegal !== 1'b0) begin n_fail++; $display("FAIL reset illegal got %b exp 0", bus.illegal); end
    n_checks++; if (bus.branchTarget !== 32'd0) begin n_fail++; $display("FAIL reset branchTarget got %h exp 0", bus.branchTarget); end
    n_checks++; if (bus.inReady !== 1'b1) begin n_fail++; $display("FAIL reset inReady got %b exp 1", bus.inReady); end
    rstN = 1'b1;
    step();
  endtask

  task automatic test_decode();
    vec_t v [15];
    v[0]  = '{32'h40B50533, 32'h0,    32'd5, 32'd7, 4'hA, 32'd5, 32'd7, 1'b0, 1'b0, 1'b0, 32'h0};
    v[1]  = '{32'hFE208EE3, 32'h0,    32'd5, 32'd7, 4'h0, 32'd5, 32'd7, 1'b1, 1'b0, 1'b1, 32'hFFFFFFFC};
    v[2]  = '{32'h4030D093, 32'h0,    32'h80000000, 32'd7, 4'hD, 32'h80000000, 32'h403, 1'b0, 1'b0, 1'b0, 32'h0};
    v[3]  = '{32'h4230D093, 32'h0,    32'h80000000, 32'd7, 4'h6, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0};
    v[4]  = '{32'hFFF00093, 32'h0,    32'd5, 32'd7, 4'h6, 32'd5, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 32'h0};
    v[5]  = '{32'h123452B7, 32'h40,   32'd5, 32'd7, 4'h6, 32'h0, 32'h12345000, 1'b0, 1'b0, 1'b0, 32'h0};
    v[6]  = '{32'h00001297, 32'h100,  32'd5, 32'd7, 4'h6, 32'h100, 32'h1000, 1'b0, 1'b0, 1'b0, 32'h0};
    v[7]  = '{32'h00812083, 32'h0,    32'd5, 32'd7, 4'h6, 32'd5, 32'd8, 1'b0, 1'b0, 1'b0, 32'h0};
    v[8]  = '{32'hFE20AE23, 32'h0,    32'd5, 32'd7, 4'h6, 32'd5, 32'hFFFFFFFC, 1'b0, 1'b0, 1'b0, 32'h0};
    v[9]  = '{32'hFE20DEE3, 32'h1000, 32'd5, 32'd7, 4'h3, 32'd5, 32'd7, 1'b1, 1'b0, 1'b1, 32'h00000FFC};
    v[10] = '{32'hFE20AEE3, 32'h1000, 32'd5, 32'd7, 4'h6, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0};
    v[11] = '{32'h40B54533, 32'h0,    32'd5, 32'd7, 4'h6, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0};
    v[12] = '{32'h00B51533, 32'h0,    32'd5, 32'd7, 4'hB, 32'd5, 32'd7, 1'b0, 1'b0, 1'b0, 32'h0};
    v[13] = '{32'h0000000B, 32'h0,    32'd5, 32'd7, 4'h6, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0};
    v[14] = '{32'h0FF0B093, 32'h0,    32'd5, 32'd7, 4'h4, 32'd5, 32'hFF, 1'b0, 1'b0, 1'b0, 32'h0};
    bus.outReady = 1'b1;
    // Offered back to back with outReady=1: every cycle must carry the next vector.
    for (int i = 0; i < 15; i++) begin
      offer(v[i].instr, v[i].pc, v[i].rs1, v[i].rs2);
      step();
      n_checks++; if (bus.outValid !== 1'b1) begin n_fail++; $display("FAIL dec[%0d] outValid got %b exp 1", i, bus.outValid); end
      n_checks++; if (bus.aluOp !== v[i].op) begin n_fail++; $display("FAIL dec[%0d] aluOp got %h exp %h", i, bus.aluOp, v[i].op); end
      n_checks++; if (bus.aluIn0 !== v[i].in0) begin n_fail++; $display("FAIL dec[%0d] aluIn0 got %h exp %h", i, bus.aluIn0, v[i].in0); end
      n_checks++; if (bus.aluIn1 !== v[i].in1) begin n_fail++; $display("FAIL dec[%0d] aluIn1 got %h exp %h", i, bus.aluIn1, v[i].in1); end
      n_checks++; if (bus.isBranch !== v[i].br) begin n_fail++; $display("FAIL dec[%0d] isBranch got %b exp %b", i, bus.isBranch, v[i].br); end
      n_checks++; if (bus.illegal !== v[i].ill) begin n_fail++; $display("FAIL dec[%0d] illegal got %b exp %b", i, bus.illegal, v[i].ill); end
      if (v[i].chk_bt) begin
        n_checks++; if (bus.branchTarget !== v[i].bt) begin n_fail++; $display("FAIL dec[%0d] branchTarget got %h exp %h", i, bus.branchTarget, v[i].bt); end
      end
    end
    bus.inValid = 1'b0;
    step();
    n_checks++; if (bus.outValid !== 1'b0) begin n_fail++; $display("FAIL dec drain outValid got %b exp 0", bus.outValid); end
  endtask

  task automatic test_back_to_back();
    bus.outReady = 1'b1;
    offer(32'h40B50533, 32'h0, 32'd5, 32'd7);
    step();
    bus.outReady = 1'b0;
    offer(32'hFFF00093, 32'h0, 32'd9, 32'd0);
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++; if (bus.inReady !== 1'b0) begin n_fail++; $display("FAIL stall[%0d] inReady got %b exp 0", k, bus.inReady); end
      step();
      n_checks++; if (bus.outValid !== 1'b1) begin n_fail++; $display("FAIL stall[%0d] outValid got %b exp 1", k, bus.outValid); end
      n_checks++; if (bus.aluOp !== 4'hA) begin n_fail++; $display("FAIL stall[%0d] aluOp got %h exp a", k, bus.aluOp); end
      n_checks++; if (bus.aluIn1 !== 32'd7) begin n_fail++; $display("FAIL stall[%0d] aluIn1 got %h exp 7", k, bus.aluIn1); end
    end
    bus.outReady = 1'b1;
    #1;
    n_checks++; if (bus.inReady !== 1'b1) begin n_fail++; $display("FAIL release inReady got %b exp 1", bus.inReady); end
    step();
    n_checks++; if (bus.outValid !== 1'b1) begin n_fail++; $display("FAIL release outValid got %b exp 1", bus.outValid); end
    n_checks++; if (bus.aluOp !== 4'h6) begin n_fail++; $display("FAIL release aluOp got %h exp 6", bus.aluOp); end
    n_checks++; if (bus.aluIn0 !== 32'd9) begin n_fail++; $display("FAIL release aluIn0 got %h exp 9", bus.aluIn0); end
    n_checks++; if (bus.aluIn1 !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL release aluIn1 got %h exp ffffffff", bus.aluIn1); end
    bus.inValid = 1'b0;
    step();
    n_checks++; if (bus.outValid !== 1'b0) begin n_fail++; $display("FAIL release drain outValid got %b exp 0", bus.outValid); end
  endtask

  task automatic test_flush();
    bus.outReady = 1'b1;
    offer(32'h40B50533, 32'h0, 32'd5, 32'd7);
    step();
    bus.outReady = 1'b0;
    offer(32'hFFF00093, 32'h0, 32'd9, 32'd0);
    bus.flush = 1'b1;
    #1;
    n_checks++; if (bus.inReady !== 1'b0) begin n_fail++; $display("FAIL flush inReady got %b exp 0", bus.inReady); end
    step();
    n_checks++; if (bus.outValid !== 1'b0) begin n_fail++; $display("FAIL flush outValid got %b exp 0", bus.outValid); end
    bus.flush = 1'b0;
    bus.inValid = 1'b0;
    step();
    n_checks++; if (bus.outValid !== 1'b0) begin n_fail++; $display("FAIL flush post outValid got %b exp 0", bus.outValid); end
    n_checks++; if (bus.aluOp !== 4'hA) begin n_fail++; $display("FAIL flush not-accepted aluOp got %h exp a", bus.aluOp); end
  endtask

  task automatic test_reset_mid_stall();
    bus.outReady = 1'b1;
    offer(32'h40B50533, 32'h200, 32'd5, 32'd7);
    step();
    bus.outReady = 1'b0;
    offer(32'hFFF00093, 32'h0, 32'd9, 32'd0);
    step();
    rstN = 1'b0;
    step();
    n_checks++; if (bus.outValid !== 1'b0) begin n_fail++; $display("FAIL rst-stall outValid got %b exp 0", bus.outValid); end
    n_checks++; if (bus.aluIn0 !== 32'd0) begin n_fail++; $display("FAIL rst-stall aluIn0 got %h exp 0", bus.aluIn0); end
    n_checks++; if (bus.aluIn1 !== 32'd0) begin n_fail++; $display("FAIL rst-stall aluIn1 got %h exp 0", bus.aluIn1); end
    n_checks++; if (bus.aluOp !== 4'h6) begin n_fail++; $display("FAIL rst-stall aluOp got %h exp 6", bus.aluOp); end
    n_checks++; if (bus.branchTarget !== 32'd0) begin n_fail++; $display("FAIL rst-stall branchTarget got %h exp 0", bus.branchTarget); end
    n_checks++; if (bus.inReady !== 1'b1) begin n_fail++; $display("FAIL rst-stall inReady got %b exp 1", bus.inReady); end
    rstN = 1'b1;
    bus.outReady = 1'b1;
    offer(32'h00000000, 32'h0, 32'd5, 32'd7);
    step();
    n_checks++; if (bus.outValid !== 1'b1) begin n_fail++; $display("FAIL zero-instr outValid got %b exp 1", bus.outValid); end
    n_checks++; if (bus.illegal !== 1'b1) begin n_fail++; $display("FAIL zero-instr illegal got %b exp 1", bus.illegal); end
    n_checks++; if (bus.aluOp !== 4'h6) begin n_fail++; $display("FAIL zero-instr aluOp got %h exp 6", bus.aluOp); end
    n_checks++; if (bus.aluIn0 !== 32'd0) begin n_fail++; $display("FAIL zero-instr aluIn0 got %h exp 0", bus.aluIn0); end
    n_checks++; if (bus.isBranch !== 1'b0) begin n_fail++; $display("FAIL zero-instr isBranch got %b exp 0", bus.isBranch); end
    bus.inValid = 1'b0;
    step();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_decode();
    test_back_to_back();
    test_flush();
    test_reset_mid_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rstN  in  1  reset, synchronous, active-low.
REQ-003 flush  in  1  discard held and incoming instruction.
REQ-004 inValid  in  1  upstream offers instr/pc/rs1Data/rs2Data.
REQ-005 inReady  out  1  stage accepts offer this cycle.
REQ-006 instr  in  32  RV32I instruction word.
REQ-007 pc  in  32  address of instr.
REQ-008 rs1Data, rs2Data  in  32 each  register-file read values.
REQ-009 outValid  out  1  registered ALU issue valid.
REQ-010 outReady  in  1  ALU/downstream consumes this cycle.
REQ-011 aluIn0, aluIn1  out  32 each  ALU left/right operands (aluIn1[4:0] = shamt for shifts).
REQ-012 aluOp  out  4  ALU encoding: 0000 eq, 0001 ne, 0010 lt, 0011 ge, 0100 ltu, 0101 geu, 0110 add, 0111 xor, 1000 or, 1001 and, 1010 sub, 1011 sll, 1100 srl, 1101 sra.
REQ-013 isBranch  out  1  aluOut is a branch condition.
REQ-014 branchTarget  out  32  pc + B-immediate.
REQ-015 illegal  out  1  instr not decodable.

Function
REQ-016 Stage SHALL be a one-entry pipeline register; all outputs except inReady SHALL be registered.
REQ-017 inReady SHALL equal (!outValid || outReady) && !flush, combinationally.
REQ-018 Transfer in occurs when inValid && inReady; outputs SHALL update on that edge, latency exactly 1 cycle.
REQ-019 outValid SHALL set on transfer in, clear when outReady && !transfer in; held outputs SHALL stay stable while outValid && !outReady.
REQ-020 Simultaneous consume and accept SHALL sustain one instruction per cycle with no bubble.
REQ-021 flush SHALL clear outValid on the next edge regardless of outReady, and no input SHALL be accepted that cycle.
REQ-022 OP (0110011): aluIn0=rs1Data, aluIn1=rs2Data; funct3 000/funct7 0000000 add, 000/0100000 sub, 001 sll, 010 lt, 011 ltu, 100 xor, 101/0000000 srl, 101/0100000 sra, 110 or, 111 and; any other funct7 illegal.
REQ-023 OP-IMM (0010011): aluIn0=rs1Data, aluIn1=sign-extended I-imm; same mapping without sub; slli requires funct7=0000000, srli 0000000, srai 0100000, else illegal.
REQ-024 BRANCH (1100011): aluIn0=rs1Data, aluIn1=rs2Data, isBranch=1; funct3 000 eq, 001 ne, 100 lt, 101 ge, 110 ltu, 111 geu; 010/011 illegal.
REQ-025 LUI (0110111): aluIn0=0, aluIn1={instr[31:12],12'b0}, add.
REQ-026 AUIPC (0010111): aluIn0=pc, aluIn1=U-imm, add.
REQ-027 LOAD (0000011) / STORE (0100011): aluIn0=rs1Data, aluIn1=sign-extended I-/S-imm, add.
REQ-028 Any other opcode, or instr[1:0]!=11: illegal=1, aluOp=add, aluIn0=aluIn1=0, isBranch=0; outValid still asserts.
REQ-029 branchTarget SHALL be computed for every accepted instruction as pc + sign-extended B-imm, modulo 2^32; meaningful only when isBranch=1.
REQ-030 isBranch SHALL be 0 for all non-BRANCH opcodes.

Reset
REQ-031 When rstN=0 at an edge: outValid=0, aluIn0=aluIn1=0, aluOp=0110, isBranch=0, illegal=0, branchTarget=0.
REQ-032 Reset SHALL dominate flush and transfer in; an instruction held mid-stall SHALL be dropped.
REQ-033 inReady SHALL be 1 combinationally while outValid=0 and flush=0, including during reset.

Verification
REQ-034 instr=0x40B50533 (sub a0,a0,a1), rs1Data=5, rs2Data=7, outReady=1 -> next cycle outValid=1, aluOp=1010, aluIn0=5, aluIn1=7.
REQ-035 instr=0xFE208EE3 (beq x1,x2,-4), pc=0x00000000 -> aluOp=0000, isBranch=1, branchTarget=0xFFFFFFFC (wrap).
REQ-036 instr=0x4030D093 (srai x1,x1,3), rs1Data=0x80000000 -> aluOp=1101, aluIn1[4:0]=3; same with funct7=0100001 -> illegal=1.
REQ-037 outReady=0 for 3 cycles with outValid=1 -> inReady=0, outputs unchanged; outReady=1 with inValid=1 -> new instruction next cycle, no bubble.
REQ-038 flush=1 while outValid=1, outReady=0, inValid=1 -> next cycle outValid=0, input not accepted.
REQ-039 rstN=0 mid-stall -> next cycle all outputs at REQ-031 values; instr=0x00000000 after reset -> illegal=1, aluOp=0110.
